// File: rtl/ccip_chan_pipe_if.sv
// ----------------------------------------------------------------------------
// ccip_chan_pipe_if
// Bundles the per-channel request signals between AFU logic (master side) and
// the CCI-P channel pipeline (slave side).
//
// Signals (all vectors are indexed by channel; payload channel c lives at
// [c*DATA_W +: DATA_W]):
//   up_valid        AFU -> pipe    request valid
//   up_data         AFU -> pipe    request payload (header + data)
//   up_almost_full  pipe -> AFU    back-pressure, registered
//   dn_valid        pipe -> port   request valid toward CCI-P Tx, registered
//   dn_data         pipe -> port   payload toward CCI-P Tx, registered
//   dn_almost_full  port -> pipe   CCI-P almost-full
//   overflow        pipe -> AFU    sticky flag: a beat was dropped on a full FIFO
// ----------------------------------------------------------------------------
interface ccip_chan_pipe_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 640
);
    logic [N_CH-1:0]        up_valid;
    logic [N_CH*DATA_W-1:0] up_data;
    logic [N_CH-1:0]        up_almost_full;
    logic [N_CH-1:0]        dn_valid;
    logic [N_CH*DATA_W-1:0] dn_data;
    logic [N_CH-1:0]        dn_almost_full;
    logic [N_CH-1:0]        overflow;

    modport master (
        output up_valid,
        output up_data,
        output dn_almost_full,
        input  up_almost_full,
        input  dn_valid,
        input  dn_data,
        input  overflow
    );

    modport slave (
        input  up_valid,
        input  up_data,
        input  dn_almost_full,
        output up_almost_full,
        output dn_valid,
        output dn_data,
        output overflow
    );
endinterface

// File: rtl/ccip_chan_pipe.sv
// ----------------------------------------------------------------------------
// ccip_chan_pipe
// Multi-channel CCI-P request pipeline. Every channel is independent: a
// STAGES-deep register pipe feeds a FIFO_DEPTH-entry skid FIFO, which drains
// one beat per clock toward CCI-P whenever the port is not almost-full.
// Back-pressure to the AFU is derived from total channel occupancy (FIFO plus
// beats still in the pipe) so that AF_SLACK beats issued after
// up_almost_full rises still fit.
//
// Ports:
//   clk      in   single clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave side of ccip_chan_pipe_if (up_*/dn_*/overflow vectors)
// ----------------------------------------------------------------------------
module ccip_chan_pipe #(
    parameter int N_CH       = 2,
    parameter int DATA_W     = 640,
    parameter int STAGES     = 2,
    parameter int FIFO_DEPTH = 64,
    parameter int AF_SLACK   = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    ccip_chan_pipe_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int AF_THR = FIFO_DEPTH - AF_SLACK - 1;

    logic [N_CH-1:0]        up_af_v;
    logic [N_CH-1:0]        dn_valid_v;
    logic [N_CH-1:0]        ovf_v;
    logic [N_CH*DATA_W-1:0] dn_data_v;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [STAGES-1:0] pv_q, pv_d;
        logic [DATA_W-1:0] pd_q [STAGES];
        logic [DATA_W-1:0] pd_d [STAGES];
        logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              dv_q, dv_d;
        logic [DATA_W-1:0] dd_q, dd_d;
        logic              ovf_q, ovf_d;
        logic              af_q, af_d;
        logic              push, pop, full, wr_en;
        logic [31:0]       occ;

        // Register pipe: stage 0 samples the AFU, stage k follows stage k-1.
        always_comb begin
            pv_d[0] = bus.up_valid[c];
            pd_d[0] = bus.up_data[c*DATA_W +: DATA_W];
            for (int k = 1; k < STAGES; k++) begin
                pv_d[k] = pv_q[k-1];
                pd_d[k] = pd_q[k-1];
            end
        end

        // Pop decision uses the count before this edge's write, so a beat
        // landing in an empty FIFO is never forwarded in the same cycle.
        assign push  = pv_q[STAGES-1];
        assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
        assign pop   = (cnt_q != '0) && !bus.dn_almost_full[c];
        // A same-edge pop frees the head slot, so a push on a full FIFO is
        // still accepted in that case.
        assign wr_en = push && (!full || pop);

        // Occupancy counts beats already committed to this channel: FIFO
        // contents plus valid beats still travelling through the pipe.
        always_comb begin
            occ = 32'(cnt_q);
            for (int k = 0; k < STAGES; k++) begin
                occ = occ + 32'(pv_q[k]);
            end
        end

        always_comb begin
            wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            cnt_d    = cnt_q;
            if (wr_en && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!wr_en && pop) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            dv_d  = pop;
            dd_d  = pop ? mem_q[rd_ptr_q] : dd_q;
            ovf_d = ovf_q | (push & full & ~pop);
            af_d  = (occ >= 32'(AF_THR));
        end

        // up_almost_full resets high so the AFU holds off until the first
        // edge after reset release.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pv_q     <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                dv_q     <= 1'b0;
                ovf_q    <= 1'b0;
                af_q     <= 1'b1;
            end else begin
                pv_q     <= pv_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                dv_q     <= dv_d;
                ovf_q    <= ovf_d;
                af_q     <= af_d;
            end
        end

        // Payload storage carries no reset; validity is tracked separately.
        always_ff @(posedge clk) begin
            for (int k = 0; k < STAGES; k++) begin
                pd_q[k] <= pd_d[k];
            end
            dd_q <= dd_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= pd_q[STAGES-1];
            end
        end

        assign up_af_v[c]                      = af_q;
        assign dn_valid_v[c]                   = dv_q;
        assign ovf_v[c]                        = ovf_q;
        assign dn_data_v[c*DATA_W +: DATA_W]   = dd_q;
    end

    assign bus.up_almost_full = up_af_v;
    assign bus.dn_valid       = dn_valid_v;
    assign bus.dn_data        = dn_data_v;
    assign bus.overflow       = ovf_v;
endmodule
